// File: rtl/axis_fifo_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : axis_fifo_pkg
// Brief   : Shared constants for the AXI4-Stream frame FIFO packed beat word.
// Revision: 1.0  initial release
// ============================================================================
package axis_fifo_pkg;

    localparam logic AXIS_USER_BAD = 1'b1;

    // Stored beat word is {tlast, tuser, tdata}
    function automatic int word_width(input int data_width);
        return data_width + 2;
    endfunction

    function automatic int tuser_bit(input int data_width);
        return data_width;
    endfunction

    function automatic int tlast_bit(input int data_width);
        return data_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : axis_fifo_ram
// Brief   : Simple dual-port RAM, one write port and one registered read port.
// Revision: 1.0  initial release
// ============================================================================
module axis_fifo_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/axis_frame_fifo_sync.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : axis_frame_fifo_sync
// Brief   : Single-clock store-and-forward AXI4-Stream frame FIFO; releases
//           only complete good frames, drops bad and overflowing frames.
// Revision: 1.0  initial release
// ============================================================================
module axis_frame_fifo_sync
    import axis_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 8,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);

    localparam int c_WORD_W  = word_width(DATA_WIDTH);
    localparam int c_TUSER   = tuser_bit(DATA_WIDTH);
    localparam int c_TLAST   = tlast_bit(DATA_WIDTH);
    localparam int c_PTR_W   = ADDR_WIDTH + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr_cur;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic                r_drop;
    logic                r_tvalid;
    logic                r_overflow;
    logic                r_bad_frame;
    logic                r_good_frame;

    logic                w_full_cur;
    logic                w_empty;
    logic                w_frame_too_big;
    logic                w_tready;
    logic                w_accept;
    logic                w_write;
    logic                w_read;
    logic [c_WORD_W-1:0] w_wr_word;
    logic [c_WORD_W-1:0] w_rd_word;

    assign w_full_cur      = (r_wr_ptr_cur - r_rd_ptr) == c_DEPTH;
    assign w_empty         = (r_rd_ptr == r_wr_ptr);
    // A single frame filling the whole memory can never commit; it must be
    // dropped or the input would stall forever.
    assign w_frame_too_big = w_full_cur && (r_wr_ptr == r_rd_ptr);
    assign w_tready        = (DROP_WHEN_FULL != 0) || r_drop || !w_full_cur || w_frame_too_big;
    assign w_accept        = input_axis_tvalid && w_tready;
    assign w_write         = w_accept && !r_drop && !w_full_cur;
    assign w_read          = (output_axis_tready || !r_tvalid) && !w_empty;
    assign w_wr_word       = {input_axis_tlast, input_axis_tuser, input_axis_tdata};

    axis_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (c_WORD_W)
    ) u_ram (
        .clk        (clk),
        .i_wr_en    (w_write),
        .i_wr_addr  (r_wr_ptr_cur[ADDR_WIDTH-1:0]),
        .i_wr_data  (w_wr_word),
        .i_rd_en    (w_read),
        .i_rd_addr  (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data  (w_rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_wr_ptr_cur <= '0;
            r_rd_ptr     <= '0;
            r_drop       <= 1'b0;
            r_tvalid     <= 1'b0;
            r_overflow   <= 1'b0;
            r_bad_frame  <= 1'b0;
            r_good_frame <= 1'b0;
        end else begin
            r_overflow   <= 1'b0;
            r_bad_frame  <= 1'b0;
            r_good_frame <= 1'b0;

            if (w_accept) begin
                if (r_drop || w_full_cur) begin
                    if (!r_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (input_axis_tlast) begin
                        r_wr_ptr_cur <= r_wr_ptr;
                        r_drop       <= 1'b0;
                    end else begin
                        r_drop       <= 1'b1;
                    end
                end else if (input_axis_tlast) begin
                    if (input_axis_tuser == AXIS_USER_BAD) begin
                        r_wr_ptr_cur <= r_wr_ptr;
                        r_bad_frame  <= 1'b1;
                    end else begin
                        r_wr_ptr_cur <= r_wr_ptr_cur + c_PTR_ONE;
                        r_wr_ptr     <= r_wr_ptr_cur + c_PTR_ONE;
                        r_good_frame <= 1'b1;
                    end
                end else begin
                    r_wr_ptr_cur <= r_wr_ptr_cur + c_PTR_ONE;
                end
            end

            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_tvalid <= 1'b1;
            end else if (output_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign input_axis_tready  = w_tready;
    assign output_axis_tdata  = w_rd_word[DATA_WIDTH-1:0];
    assign output_axis_tuser  = w_rd_word[c_TUSER];
    assign output_axis_tlast  = w_rd_word[c_TLAST];
    assign output_axis_tvalid = r_tvalid;
    assign overflow           = r_overflow;
    assign bad_frame          = r_bad_frame;
    assign good_frame         = r_good_frame;

endmodule
`default_nettype wire
